// File: rtl/counterverilog_pkg.sv
// rtl/counterverilog_pkg.sv - shared width default and terminal-count constant
package counterverilog_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam logic [DEFAULT_WIDTH-1:0] DEFAULT_TERMINAL = '1;

endpackage

// File: rtl/counterverilog.sv
// rtl/counterverilog.sv - free-running up counter with enable and terminal-count flag
module counterverilog
  import counterverilog_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cnt_ena,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  localparam logic [WIDTH-1:0] TERMINAL = '1;
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  // Natural modulo-2^WIDTH wrap: all ones + 1 rolls to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (cnt_ena) begin
      count <= count + ONE;
    end
  end

  assign tc = (count == TERMINAL);

endmodule

// File: tb/tb_counterverilog.sv
// tb/tb_counterverilog.sv - directed table-driven bench for counterverilog
module tb_counterverilog;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cnt_ena = 1'b0;
  logic        cnt_ena4 = 1'b0;
  logic [15:0] count;
  logic        tc;
  logic [3:0]  count4;
  logic        tc4;

  int passed = 0;
  int total  = 0;

  counterverilog #(.WIDTH(16)) dut (
    .clk     (clk),
    .reset   (reset),
    .cnt_ena (cnt_ena),
    .count   (count),
    .tc      (tc)
  );

  counterverilog #(.WIDTH(4)) dut4 (
    .clk     (clk),
    .reset   (reset),
    .cnt_ena (cnt_ena4),
    .count   (count4),
    .tc      (tc4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        ena;
    logic [31:0] exp_count;
    logic        exp_tc;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    else
      passed++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[$];

  initial begin
    // Power-up pulse: reset high from 5 ns to 15 ns with enable low.
    #5 reset = 1'b1;
    #1;
    chk("por_count", 32'(count), 32'd0);
    chk("por_tc", 32'(tc), 32'd0);
    chk("por_known", 32'($isunknown({count, tc, count4, tc4})), 32'd0);
    #9 reset = 1'b0;
    #1;
    step();
    step();
    chk("por_hold_count", 32'(count), 32'd0);
    chk("por_hold_tc", 32'(tc), 32'd0);

    for (int i = 1; i <= 7; i++) vecs.push_back('{1'b0, 1'b1, 32'(i), 1'b0});
    for (int i = 0; i < 5; i++)  vecs.push_back('{1'b0, 1'b0, 32'd7, 1'b0});
    for (int i = 8; i <= 10; i++) vecs.push_back('{1'b0, 1'b1, 32'(i), 1'b0});
    for (int i = 0; i < 3; i++)  vecs.push_back('{1'b1, 1'b1, 32'd0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 32'd0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 32'd1, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 32'd2, 1'b0});

    foreach (vecs[i]) begin
      reset   = vecs[i].rst;
      cnt_ena = vecs[i].ena;
      step();
      chk($sformatf("vec%0d_count", i), 32'(count), vecs[i].exp_count);
      chk($sformatf("vec%0d_tc", i), 32'(tc), 32'(vecs[i].exp_tc));
    end

    // Run up to 100, then reset between edges.
    cnt_ena = 1'b1;
    for (int i = 0; i < 98; i++) step();
    chk("run_to_100", 32'(count), 32'd100);
    #2 reset = 1'b1;
    #1;
    chk("async_mid_count", 32'(count), 32'd0);
    chk("async_mid_tc", 32'(tc), 32'd0);
    #1 reset = 1'b0;
    step();
    chk("resume_after_reset", 32'(count), 32'd1);

    // Full 16-bit sequence from zero to wrap.
    #1 reset = 1'b1;
    #1 reset = 1'b0;
    chk("wrap_start", 32'(count), 32'd0);
    for (int i = 0; i < 65534; i++) step();
    chk("pre_term_count", 32'(count), 32'd65534);
    chk("pre_term_tc", 32'(tc), 32'd0);
    step();
    chk("term_count", 32'(count), 32'd65535);
    chk("term_tc", 32'(tc), 32'd1);
    cnt_ena = 1'b0;
    step();
    step();
    chk("term_hold_count", 32'(count), 32'd65535);
    chk("term_hold_tc", 32'(tc), 32'd1);
    cnt_ena = 1'b1;
    step();
    chk("wrap_count", 32'(count), 32'd0);
    chk("wrap_tc", 32'(tc), 32'd0);
    cnt_ena = 1'b0;

    // Narrow instance: 15 -> 0.
    cnt_ena4 = 1'b1;
    for (int i = 0; i < 14; i++) step();
    chk("w4_pre_count", 32'(count4), 32'd14);
    chk("w4_pre_tc", 32'(tc4), 32'd0);
    step();
    chk("w4_term_count", 32'(count4), 32'd15);
    chk("w4_term_tc", 32'(tc4), 32'd1);
    step();
    chk("w4_wrap_count", 32'(count4), 32'd0);
    chk("w4_wrap_tc", 32'(tc4), 32'd0);
    cnt_ena4 = 1'b0;
    chk("end_known", 32'($isunknown({count, tc, count4, tc4})), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/counterverilog.md
COUNTERVERILOG -- requirements
Module: counterverilog

Interface
REQ-001 Parameter WIDTH, default 16: counter width in bits; legal range 2..32.
REQ-002 Port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-003 Port reset, input, 1: asynchronous, active-high reset; clears all state immediately when high.
REQ-004 Port cnt_ena, input, 1: count enable, sampled on the rising edge of clk.
REQ-005 Port count, output, WIDTH: current counter value, driven directly from a register.
REQ-006 Port tc, output, 1: terminal-count flag, high while count equals all ones.

Function
REQ-007 The block SHALL use one clock (clk) with an asynchronous, active-high reset (reset).
REQ-008 On each rising clk edge with reset low and cnt_ena high, count SHALL become count+1 modulo 2^WIDTH.
REQ-009 On each rising clk edge with reset low and cnt_ena low, count SHALL hold its value.
REQ-010 Increment latency SHALL be one cycle: the new value is visible after the enabling edge, with no pipeline.
REQ-011 Wrap-around: from all ones (65535 at WIDTH=16) with cnt_ena high, the next edge SHALL give count=0; no saturation and no stop.
REQ-012 tc SHALL be a combinational decode of the count register: 1 when count == 2^WIDTH-1, else 0, independent of cnt_ena.
REQ-013 tc SHALL be high for exactly one enabled cycle per full count sequence and SHALL stay high while the counter holds at all ones.
REQ-014 If reset and cnt_ena are both high, reset SHALL win and count SHALL be 0.
REQ-015 The outputs SHALL never be X/Z after the first reset assertion; cnt_ena transitions away from the clock edge SHALL not affect count.

Reset
REQ-016 While reset is high, count SHALL be 0 and tc SHALL be 0, asynchronously, without waiting for a clk edge.
REQ-017 Reset asserted in the middle of counting SHALL clear count to 0 immediately; counting SHALL resume from 0 on the first rising edge after reset deassertion with cnt_ena high.
REQ-018 Reset deassertion SHALL not by itself produce an increment; it only removes the clear.

Structure
REQ-019 A shared package SHALL hold the WIDTH default constant (16) and the derived terminal value constant (all ones).
REQ-020 The design SHALL be flat: one count register process plus one tc comparator; no sub-module is required.
REQ-021 The design SHALL be synthesizable with no latches and no combinational loops; tc SHALL be the only combinational output.

Verification
REQ-022 Power-up: pulse reset high at 5 ns for 10 ns with cnt_ena=0 -> count=0, tc=0, holding through later clk edges.
REQ-023 Enable counting: set cnt_ena=1 after reset, with a 10 ns clk period -> count reads 1, 2, 3, ... on successive rising edges, tc=0.
REQ-024 Hold: drop cnt_ena for 5 cycles at count=7 -> count stays 7 for those 5 cycles, then resumes at 8 once cnt_ena returns high.
REQ-025 Wrap and tc: count 65535 enabled cycles from 0 -> count=65535 with tc=1; the next enabled edge gives count=0 with tc=0. Repeat with WIDTH=4: 15 -> 0.
REQ-026 Async reset mid-run: assert reset between clk edges at count=100 -> count=0 immediately, before the next edge; after release with cnt_ena=1, the next edge gives 1.
REQ-027 Simultaneous: hold reset=1 and cnt_ena=1 over 3 edges -> count=0 and tc=0 throughout.
